// File: rtl/dbg_display_pkg.sv
// Shared constants and types for the debug display front-end:
// active-low 7-segment table, blank pattern and index FSM states.
package dbg_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry n is the gfedcba pattern for hex digit n (index 15 is leftmost)
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCROLL = 1'b1
  } idx_state_e;

endpackage

// File: rtl/key_debounce.sv
// Step-key conditioning: 2-FF synchroniser, stable-level debounce counter
// and a one-cycle pulse on each accepted press (high-to-low transition).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    // Any sample matching the accepted level restarts the count
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
        pulse_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/dbg_display_ctrl.sv
// Debug display front-end: step-key pulse, manual/auto-scroll source index,
// registered display word and 7-segment decode. Optional DBG_LEADING_ZERO_BLANK_EN.
module dbg_display_ctrl
  import dbg_display_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int DATA_W          = 32,
  parameter int DIGITS          = DATA_W / 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCROLL_DIV      = 50000000,
  parameter int SEL_W           = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step_key_n,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       scroll_en,
  input  logic                       freeze,
  input  logic [DATA_W-1:0]          inst,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       step_pulse,
  output logic [SEL_W-1:0]           cur_idx,
  output logic [7*DIGITS-1:0]        hex
);

  localparam int SCNT_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  idx_state_e        state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] src_word;

  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
    return (32'(s) < NUM_REGS) ? s : '0;
  endfunction

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk         (clk),
    .reset       (reset),
    .key_n       (step_key_n),
    .press_pulse (step_pulse)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    scnt_d  = scnt_q;
    if (!freeze) begin
      case (state_q)
        ST_MANUAL: begin
          if (scroll_en) begin
            state_d = ST_SCROLL;
            scnt_d  = '0;
          end else begin
            idx_d = clamp_sel(sel);
          end
        end
        default: begin
          // Leaving scroll mode takes priority over a terminal count
          if (!scroll_en) begin
            state_d = ST_MANUAL;
            idx_d   = clamp_sel(sel);
          end else if (scnt_q == SCNT_W'(SCROLL_DIV - 1)) begin
            scnt_d = '0;
            idx_d  = (idx_q == SEL_W'(NUM_REGS - 1)) ? '0 : idx_q + SEL_W'(1);
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    src_word = (idx_q == '0) ? inst : regs_flat[32'(idx_q) * DATA_W +: DATA_W];
    word_d   = freeze ? word_q : src_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_MANUAL;
      idx_q   <= '0;
      scnt_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      scnt_q  <= scnt_d;
      word_q  <= word_d;
    end
  end

  assign cur_idx = idx_q;

`ifdef DBG_LEADING_ZERO_BLANK_EN
  logic seen_nz;
  always_comb begin
    hex     = '1;
    seen_nz = 1'b0;
    // Walk from the top digit down; digit 0 is always shown
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (word_q[4*d +: 4] != 4'h0) seen_nz = 1'b1;
      hex[7*d +: 7] = (seen_nz || d == 0) ? HEX_SEG[word_q[4*d +: 4]] : SEG_BLANK;
    end
  end
`else
  always_comb begin
    hex = '1;
    for (int d = 0; d < DIGITS; d++) begin
      hex[7*d +: 7] = HEX_SEG[word_q[4*d +: 4]];
    end
  end
`endif

endmodule

// File: tb/tb_dbg_display_ctrl.sv
// Directed bench for dbg_display_ctrl: reset, debounce, manual select,
// clamp, auto-scroll wrap, freeze, reset mid-scroll and leading-zero display.
module tb_dbg_display_ctrl;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          step_key_n;
  logic [5:0]    sel_a;
  logic [1:0]    sel_b;
  logic          scroll_en;
  logic          freeze;
  logic [DW-1:0] inst;
  logic [32*DW-1:0] regs_a;
  logic [4*DW-1:0]  regs_b;
  logic          step_pulse_a, step_pulse_b;
  logic [5:0]    cur_idx_a;
  logic [1:0]    cur_idx_b;
  logic [55:0]   hex_a, hex_b;

  int vectors = 0;
  int miscompares = 0;
  int pulse_cnt;
  int pulse_at;

  // Digits 7..0, left to right
  localparam logic [55:0] INST_HEX  = {7'h00, 7'h46, 7'h24, 7'h24, 7'h40, 7'h40, 7'h40, 7'h19};
  localparam logic [55:0] REG1B_HEX = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
`ifdef DBG_LEADING_ZERO_BLANK_EN
  localparam logic [55:0] ZERO_HEX  = {{7{7'h7F}}, 7'h40};
  localparam logic [55:0] ABCD_HEX  = {{4{7'h7F}}, 7'h08, 7'h03, 7'h46, 7'h21};
  localparam logic [55:0] ABCE_HEX  = {{4{7'h7F}}, 7'h08, 7'h03, 7'h46, 7'h06};
  localparam logic [55:0] F_HEX     = {7'h7F, 7'h7F, 7'h0E, {5{7'h40}}};
`else
  localparam logic [55:0] ZERO_HEX  = {8{7'h40}};
  localparam logic [55:0] ABCD_HEX  = {{4{7'h40}}, 7'h08, 7'h03, 7'h46, 7'h21};
  localparam logic [55:0] ABCE_HEX  = {{4{7'h40}}, 7'h08, 7'h03, 7'h46, 7'h06};
  localparam logic [55:0] F_HEX     = {7'h40, 7'h40, 7'h0E, {5{7'h40}}};
`endif

  always #5 clk = ~clk;

  dbg_display_ctrl #(
    .NUM_REGS(32), .DATA_W(DW), .DIGITS(8),
    .DEBOUNCE_CYCLES(8), .SCROLL_DIV(4), .SEL_W(6)
  ) dut_a (
    .clk(clk), .reset(reset), .step_key_n(step_key_n), .sel(sel_a),
    .scroll_en(scroll_en), .freeze(freeze), .inst(inst), .regs_flat(regs_a),
    .step_pulse(step_pulse_a), .cur_idx(cur_idx_a), .hex(hex_a)
  );

  dbg_display_ctrl #(
    .NUM_REGS(4), .DATA_W(DW), .DIGITS(8),
    .DEBOUNCE_CYCLES(8), .SCROLL_DIV(4), .SEL_W(2)
  ) dut_b (
    .clk(clk), .reset(reset), .step_key_n(1'b1), .sel(sel_b),
    .scroll_en(scroll_en), .freeze(freeze), .inst(inst), .regs_flat(regs_b),
    .step_pulse(step_pulse_b), .cur_idx(cur_idx_b), .hex(hex_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key_cycles(input logic lvl, input int n);
    step_key_n = lvl;
    for (int i = 1; i <= n; i++) begin
      tick(1);
      if (step_pulse_a) begin
        pulse_cnt++;
        pulse_at = i;
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    step_key_n = 1'b1;
    sel_a      = '0;
    sel_b      = '0;
    scroll_en  = 1'b0;
    freeze     = 1'b0;
    inst       = 32'h8C220004;
    for (int k = 0; k < 32; k++) regs_a[k*DW +: DW] = {8{k[3:0]}};
    regs_a[5*DW +: DW] = 32'h0000ABCD;
    regs_a[6*DW +: DW] = 32'h00000000;
    regs_a[7*DW +: DW] = 32'h00F00000;
    regs_b = {32'h33333333, 32'h22222222, 32'h12345678, 32'h00000000};

    tick(3);
    chk("reset_hex", 64'(hex_a), 64'(ZERO_HEX));
    chk("reset_idx", 64'(cur_idx_a), 64'd0);
    chk("reset_pulse", 64'(step_pulse_a), 64'd0);

    reset = 1'b0;
    pulse_cnt = 0;
    pulse_at  = 0;
    key_cycles(1'b1, 6);
    chk("idle_pulses", 64'(pulse_cnt), 64'd0);
    chk("idle_idx", 64'(cur_idx_a), 64'd0);

    // Three short bounces, then a solid press
    for (int b = 0; b < 3; b++) begin
      key_cycles(1'b0, 3);
      key_cycles(1'b1, 2);
    end
    chk("bounce_pulses", 64'(pulse_cnt), 64'd0);
    key_cycles(1'b0, 20);
    chk("press_pulses", 64'(pulse_cnt), 64'd1);
    chk("press_latency", 64'(pulse_at), 64'd10);
    pulse_cnt = 0;
    key_cycles(1'b1, 20);
    chk("release_pulses", 64'(pulse_cnt), 64'd0);

    sel_a = 6'd5;
    tick(1);
    chk("sel5_idx", 64'(cur_idx_a), 64'd5);
    tick(1);
    chk("sel5_hex", 64'(hex_a), 64'(ABCD_HEX));
    regs_a[5*DW +: DW] = 32'h0000ABCE;
    tick(1);
    chk("live_reg_hex", 64'(hex_a), 64'(ABCE_HEX));

    sel_a = 6'd6;
    tick(2);
    chk("zero_word_hex", 64'(hex_a), 64'(ZERO_HEX));
    sel_a = 6'd7;
    tick(2);
    chk("f_word_hex", 64'(hex_a), 64'(F_HEX));

    sel_a = 6'd40;
    tick(2);
    chk("clamp_idx", 64'(cur_idx_a), 64'd0);
    chk("clamp_hex", 64'(hex_a), 64'(INST_HEX));

    sel_b = 2'd2;
    tick(2);
    chk("scroll_start_idx", 64'(cur_idx_b), 64'd2);
    scroll_en = 1'b1;
    tick(1);
    chk("scroll_enter_keep", 64'(cur_idx_b), 64'd2);
    tick(3);
    chk("scroll_pre_term", 64'(cur_idx_b), 64'd2);
    tick(1);
    chk("scroll_to3", 64'(cur_idx_b), 64'd3);
    tick(4);
    chk("scroll_wrap0", 64'(cur_idx_b), 64'd0);
    tick(4);
    chk("scroll_to1", 64'(cur_idx_b), 64'd1);

    freeze = 1'b1;
    tick(10);
    chk("freeze_idx", 64'(cur_idx_b), 64'd1);
    chk("freeze_hex", 64'(hex_b), 64'(INST_HEX));
    freeze = 1'b0;
    tick(3);
    chk("unfreeze_idx", 64'(cur_idx_b), 64'd1);
    chk("unfreeze_hex", 64'(hex_b), 64'(REG1B_HEX));
    tick(1);
    chk("unfreeze_to2", 64'(cur_idx_b), 64'd2);

    tick(2);
    reset = 1'b1;
    tick(1);
    chk("midscroll_reset_idx", 64'(cur_idx_b), 64'd0);
    chk("midscroll_reset_hex", 64'(hex_b), 64'(ZERO_HEX));
    scroll_en = 1'b0;
    sel_b     = 2'd1;
    tick(1);
    reset = 1'b0;
    tick(2);
    chk("manual_after_reset", 64'(cur_idx_b), 64'd1);

    // Terminal count coincides with scroll_en falling
    scroll_en = 1'b1;
    tick(4);
    scroll_en = 1'b0;
    sel_b     = 2'd3;
    tick(1);
    chk("term_vs_exit", 64'(cur_idx_b), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
